// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, alu_op encodings and R-type funct values
package alu_pkg;
  localparam logic [3:0] ALU_AND     = 4'd0;
  localparam logic [3:0] ALU_OR      = 4'd1;
  localparam logic [3:0] ALU_ADD     = 4'd2;
  localparam logic [3:0] ALU_SUB     = 4'd6;
  localparam logic [3:0] ALU_SLT     = 4'd7;
  localparam logic [3:0] ALU_NOR     = 4'd12;
  localparam logic [3:0] ALU_ILLEGAL = 4'd15;
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_FUNCT = 2'b10;
  localparam logic [1:0] OP_SLT   = 2'b11;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;
endpackage

// File: rtl/alu_ctl_decode.sv
// alu_ctl_decode: maps alu_op/funct to the 4-bit ALU control code and flags unsupported functs
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] ctl,
  output logic       illegal
);
  logic [3:0] w_fctl;
  // funct lookup for R-type, then alu_op override for the fixed operations
  always_comb begin
    w_fctl  = funct == F_ADD ? ALU_ADD :
              funct == F_SUB ? ALU_SUB :
              funct == F_AND ? ALU_AND :
              funct == F_OR  ? ALU_OR  :
              funct == F_NOR ? ALU_NOR :
              funct == F_SLT ? ALU_SLT : ALU_ILLEGAL;
    ctl     = alu_op == OP_ADD ? ALU_ADD :
              alu_op == OP_SUB ? ALU_SUB :
              alu_op == OP_SLT ? ALU_SLT : w_fctl;
    illegal = (alu_op == OP_FUNCT) && (w_fctl == ALU_ILLEGAL);
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU control decode, operand select and forwarding
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [1:0]      alu_op,
  input  logic [5:0]      funct,
  input  logic            alu_src,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rs_idx,
  input  logic [4:0]      rt_idx,
  input  logic [4:0]      rd_idx,
  input  logic            reg_write,
  input  logic            exmem_reg_write,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic            ex_valid,
  output logic [3:0]      alu_ctl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            illegal
);
  logic [3:0]      w_ctl;
  logic            w_illegal;
  logic [XLEN-1:0] w_rs_fwd, w_rt_fwd;
  logic            r_valid, r_illegal, r_src, r_reg_write;
  logic [3:0]      r_ctl;
  logic [XLEN-1:0] r_rs_data, r_rt_data, r_imm;
  logic [4:0]      r_rs_idx, r_rt_idx, r_rd;

  alu_ctl_decode u_dec (
    .alu_op (alu_op),
    .funct  (funct),
    .ctl    (w_ctl),
    .illegal(w_illegal)
  );

  // stage registers: reset/flush load a bubble, stall holds, otherwise capture decode outputs
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid     <= 1'b0;
      r_illegal   <= 1'b0;
      r_src       <= 1'b0;
      r_reg_write <= 1'b0;
      r_ctl       <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_rs_idx    <= '0;
      r_rt_idx    <= '0;
      r_rd        <= '0;
    end else if (!stall) begin
      r_valid     <= in_valid;
      r_illegal   <= w_illegal;
      r_src       <= alu_src;
      r_reg_write <= reg_write & in_valid & ~w_illegal;
      r_ctl       <= w_ctl;
      r_rs_data   <= rs_data;
      r_rt_data   <= rt_data;
      r_imm       <= imm;
      r_rs_idx    <= rs_idx;
      r_rt_idx    <= rt_idx;
      r_rd        <= rd_idx;
    end
  end

  // forwarding: EX/MEM before MEM/WB, register 0 never forwarded
  always_comb begin
    w_rs_fwd = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == r_rs_idx) ? exmem_result :
               (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == r_rs_idx) ? memwb_result : r_rs_data;
    w_rt_fwd = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == r_rt_idx) ? exmem_result :
               (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == r_rt_idx) ? memwb_result : r_rt_data;
  end

  assign alu_a         = w_rs_fwd;
  assign alu_b         = r_src ? r_imm : w_rt_fwd;
  assign ex_store_data = w_rt_fwd;
  assign ex_valid      = r_valid;
  assign alu_ctl       = r_ctl;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_reg_write;
  assign illegal       = r_illegal;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven checks of id_ex_stage plus stall/flush/reset sequences
module tb_id_ex_stage;
  logic        clk = 0;
  logic        reset, stall, flush, in_valid, alu_src, reg_write;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] rs_data, rt_data, imm, exmem_result, memwb_result;
  logic [4:0]  rs_idx, rt_idx, rd_idx, exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic        ex_valid, ex_reg_write, illegal;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0]  ex_rd;
  int n_chk = 0;
  int n_fail = 0;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_op(alu_op), .funct(funct), .alu_src(alu_src), .rs_data(rs_data), .rt_data(rt_data),
    .imm(imm), .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx), .reg_write(reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        src, iv, rw;
    logic [4:0]  rs_idx, rt_idx, rd;
    logic [31:0] rs, rt, imm;
    logic        exw;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        mww;
    logic [4:0]  mwrd;
    logic [31:0] mwres;
    logic [3:0]  e_ctl;
    logic        e_ill, e_v, e_rw;
    logic [31:0] e_a, e_b, e_sd;
  } vec_t;

  vec_t v[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    alu_op = t.op; funct = t.funct; alu_src = t.src; in_valid = t.iv; reg_write = t.rw;
    rs_idx = t.rs_idx; rt_idx = t.rt_idx; rd_idx = t.rd; rs_data = t.rs; rt_data = t.rt; imm = t.imm;
    exmem_reg_write = t.exw; exmem_rd = t.exrd; exmem_result = t.exres;
    memwb_reg_write = t.mww; memwb_rd = t.mwrd; memwb_result = t.mwres;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ex_valid"}, 32'(ex_valid), 0);
    chk({tag, " alu_ctl"}, 32'(alu_ctl), 0);
    chk({tag, " ex_reg_write"}, 32'(ex_reg_write), 0);
    chk({tag, " illegal"}, 32'(illegal), 0);
    chk({tag, " ex_rd"}, 32'(ex_rd), 0);
    chk({tag, " alu_a"}, alu_a, 0);
    chk({tag, " alu_b"}, alu_b, 0);
    chk({tag, " store"}, ex_store_data, 0);
  endtask

  initial begin
    //       op    funct src iv rw rsi rti rd rs        rt        imm           exw exrd exres  mww mwrd mwres    ctl ill v rw a         b             sd
    v[0]  = '{2'b10, 6'h22, 0, 1, 1, 1, 2, 3, 10,       3,        0,            0, 0, 0,     0, 0, 0,       6,  0, 1, 1, 10,       3,            3};
    v[1]  = '{2'b00, 6'h00, 1, 1, 1, 1, 2, 4, 5,        9,        32'hFFFFFFFC, 0, 0, 0,     0, 0, 0,       2,  0, 1, 1, 5,        32'hFFFFFFFC, 9};
    v[2]  = '{2'b10, 6'h27, 0, 1, 1, 1, 2, 5, 32'hF0F0, 32'h0F0F, 0,            0, 0, 0,     0, 0, 0,       12, 0, 1, 1, 32'hF0F0, 32'h0F0F,     32'h0F0F};
    v[3]  = '{2'b10, 6'h24, 0, 1, 1, 1, 2, 6, 6,        7,        0,            0, 0, 0,     0, 0, 0,       0,  0, 1, 1, 6,        7,            7};
    v[4]  = '{2'b10, 6'h25, 0, 1, 1, 1, 2, 7, 6,        7,        0,            0, 0, 0,     0, 0, 0,       1,  0, 1, 1, 6,        7,            7};
    v[5]  = '{2'b10, 6'h20, 0, 1, 1, 1, 2, 8, 6,        7,        0,            0, 0, 0,     0, 0, 0,       2,  0, 1, 1, 6,        7,            7};
    v[6]  = '{2'b10, 6'h2A, 0, 1, 1, 1, 2, 9, 6,        7,        0,            0, 0, 0,     0, 0, 0,       7,  0, 1, 1, 6,        7,            7};
    v[7]  = '{2'b01, 6'h3F, 0, 1, 1, 1, 2, 10, 6,       7,        0,            0, 0, 0,     0, 0, 0,       6,  0, 1, 1, 6,        7,            7};
    v[8]  = '{2'b11, 6'h00, 0, 1, 1, 1, 2, 11, 6,       7,        0,            0, 0, 0,     0, 0, 0,       7,  0, 1, 1, 6,        7,            7};
    v[9]  = '{2'b00, 6'h00, 0, 1, 1, 5, 6, 12, 1,       2,        0,            1, 5, 32'hAA, 1, 5, 32'hBB, 2,  0, 1, 1, 32'hAA,   2,            2};
    v[10] = '{2'b00, 6'h00, 0, 1, 1, 5, 6, 12, 1,       2,        0,            0, 5, 32'hAA, 1, 5, 32'hBB, 2,  0, 1, 1, 32'hBB,   2,            2};
    v[11] = '{2'b00, 6'h00, 0, 1, 1, 0, 0, 13, 0,       0,        0,            1, 0, 7,     1, 0, 9,       2,  0, 1, 1, 0,        0,            0};
    v[12] = '{2'b00, 6'h00, 0, 1, 1, 1, 7, 14, 1,       4,        0,            1, 8, 32'h55, 1, 7, 32'h1234, 2, 0, 1, 1, 1,       32'h1234,     32'h1234};
    v[13] = '{2'b00, 6'h00, 1, 1, 1, 1, 7, 14, 1,       4,        32'h55,       1, 8, 32'h66, 1, 7, 32'h1234, 2, 0, 1, 1, 1,       32'h55,       32'h1234};
    v[14] = '{2'b10, 6'h24, 0, 0, 1, 1, 2, 15, 6,       7,        0,            0, 0, 0,     0, 0, 0,       0,  0, 0, 0, 6,        7,            7};
    v[15] = '{2'b10, 6'h3F, 0, 1, 1, 1, 2, 16, 6,       7,        0,            0, 0, 0,     0, 0, 0,       15, 1, 1, 0, 6,        7,            7};

    reset = 1; stall = 0; flush = 0;
    drive(v[0]);
    exmem_reg_write = 0; memwb_reg_write = 0;
    tick(); tick();
    chk_zero("reset");

    reset = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(v[i]);
      tick();
      chk($sformatf("v%0d alu_ctl", i), 32'(alu_ctl), 32'(v[i].e_ctl));
      chk($sformatf("v%0d illegal", i), 32'(illegal), 32'(v[i].e_ill));
      chk($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(v[i].e_v));
      chk($sformatf("v%0d ex_reg_write", i), 32'(ex_reg_write), 32'(v[i].e_rw));
      chk($sformatf("v%0d ex_rd", i), 32'(ex_rd), 32'(v[i].rd));
      chk($sformatf("v%0d alu_a", i), alu_a, v[i].e_a);
      chk($sformatf("v%0d alu_b", i), alu_b, v[i].e_b);
      chk($sformatf("v%0d store", i), ex_store_data, v[i].e_sd);
    end

    // stall holds the loaded instruction while inputs change
    @(negedge clk);
    drive(v[0]);
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(v[2 + c]);
      stall = 1;
      tick();
      chk($sformatf("stall%0d alu_ctl", c), 32'(alu_ctl), 6);
      chk($sformatf("stall%0d alu_a", c), alu_a, 10);
      chk($sformatf("stall%0d alu_b", c), alu_b, 3);
      chk($sformatf("stall%0d ex_valid", c), 32'(ex_valid), 1);
      chk($sformatf("stall%0d ex_rd", c), 32'(ex_rd), 3);
    end
    // forwarding still acts during a stall
    @(negedge clk);
    exmem_reg_write = 1; exmem_rd = 1; exmem_result = 32'h77;
    #1;
    chk("stall fwd alu_a", alu_a, 32'h77);
    chk("stall fwd alu_b", alu_b, 3);
    // flush with stall loads a bubble
    flush = 1;
    exmem_reg_write = 0;
    tick();
    chk("flush ex_valid", 32'(ex_valid), 0);
    chk("flush ex_reg_write", 32'(ex_reg_write), 0);
    chk("flush alu_ctl", 32'(alu_ctl), 0);
    chk("flush alu_a", alu_a, 0);

    // illegal instruction, then reset during a stall
    @(negedge clk);
    flush = 0; stall = 0;
    drive(v[15]);
    tick();
    chk("ill alu_ctl", 32'(alu_ctl), 15);
    chk("ill illegal", 32'(illegal), 1);
    chk("ill ex_reg_write", 32'(ex_reg_write), 0);
    @(negedge clk);
    drive(v[0]);
    exmem_reg_write = 0; memwb_reg_write = 0;
    reset = 1; stall = 1;
    tick();
    chk_zero("reset stall");

    // reset together with flush
    @(negedge clk);
    reset = 0; stall = 0;
    tick();
    chk("reload alu_ctl", 32'(alu_ctl), 6);
    @(negedge clk);
    reset = 1; flush = 1;
    tick();
    chk_zero("reset flush");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 5-stage core: it captures decoded operands from the decode stage and feeds the EX-stage ALU. It also produces the 4-bit ALU control code from `alu_op`/`funct`, selects the immediate or register operand, and resolves EX/MEM and MEM/WB data forwarding. It supports hazard-unit stall (hold) and flush (bubble).

## Interface
- `XLEN`, 32, datapath width
- `clk` in 1, rising-edge clock
- `reset` in 1, synchronous, active-high
- `stall` in 1, hold all stage registers
- `flush` in 1, load a bubble
- `in_valid` in 1, decode stage presents an instruction
- `alu_op` in 2, 00 add, 01 sub, 10 by funct, 11 slt
- `funct` in 6, R-type function field
- `alu_src` in 1, 1: B = `imm`, 0: B = rt value
- `rs_data`, `rt_data` in XLEN, register-file read data
- `imm` in XLEN, already sign-extended immediate
- `rs_idx`, `rt_idx`, `rd_idx` in 5, register indices
- `reg_write` in 1, instruction writes `rd_idx`
- `exmem_reg_write` in 1, `exmem_rd` in 5, `exmem_result` in XLEN, EX/MEM forward source
- `memwb_reg_write` in 1, `memwb_rd` in 5, `memwb_result` in XLEN, MEM/WB forward source
- `ex_valid` out 1, stage holds a real instruction
- `alu_ctl` out 4, ALU control code (registered)
- `alu_a`, `alu_b` out XLEN, forwarded ALU operands (combinational from registered fields)
- `ex_store_data` out XLEN, forwarded rt value for stores
- `ex_rd` out 5, `ex_reg_write` out 1, destination for later stages
- `illegal` out 1, registered: `alu_op`=10 with an unsupported funct

## Operation
- ALU control decode:
  - `alu_op` 00→2 (add), 01→6 (sub), 11→7 (slt).
  - `alu_op` 10 by funct: 0x20→2, 0x22→6, 0x24→0 (and), 0x25→1 (or), 0x27→12 (nor), 0x2A→7.
  - Any other funct→15 and `illegal`=1.
  - `illegal`=1 also forces the registered `reg_write` to 0. `ex_valid` stays 1.
- Register update priority per clock edge: `reset` > `flush` > `stall` > load.
  - Load: capture all inputs, `ex_valid`←`in_valid`, `ex_reg_write`←`reg_write & in_valid & ~illegal_decode`.
  - Bubble (reset or flush): every stage register cleared to 0, so `alu_ctl`=0 and `ex_valid`=`ex_reg_write`=`illegal`=0.
  - Stall: every register holds its value. Forward inputs may still change the operand outputs.
- Forwarding, applied independently to the rs and rt paths:
  - If `exmem_reg_write` and `exmem_rd`≠0 and `exmem_rd`==idx, use `exmem_result`.
  - Else if `memwb_reg_write` and `memwb_rd`≠0 and `memwb_rd`==idx, use `memwb_result`.
  - Else use the registered data.
  - EX/MEM wins when both match. Register 0 is never forwarded.
- `alu_a` = forwarded rs. `ex_store_data` = forwarded rt. `alu_b` = registered `imm` if registered `alu_src`, else forwarded rt.
- No arithmetic in this block; all data widths are XLEN and pass through unmodified.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on registered outputs after edge N.
- Operand outputs settle combinationally in the same cycle as the forward inputs.
- Reset: all outputs 0 on the first edge with `reset`=1. `alu_a`/`alu_b`/`ex_store_data` become 0 unless forward inputs match index 0, which is never forwarded.
- `flush` and `stall` together: flush wins, and the bubble is loaded.
- `reset` asserted mid-stall or mid-flush: reset wins on that edge.
- `in_valid`=0 on load: fields are captured, but `ex_valid` and `ex_reg_write` become 0.

## Structure
- Package `alu_pkg` holds:
  - ALU control constants: AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12, ILLEGAL=15.
  - `alu_op` encodings.
  - funct constants.
- One sub-module, `alu_ctl_decode`: combinational (`alu_op`, `funct`) → (`ctl`, `illegal`).
- Forwarding muxes and stage registers live in `id_ex_stage`.

## Test plan
- R-type load: `alu_op`=10, `funct`=0x22, `rs_data`=10, `rt_data`=3, `in_valid`=1 → next cycle `alu_ctl`=6, `alu_a`=10, `alu_b`=3, `ex_valid`=1.
- Immediate select and NOR: `alu_src`=1, `imm`=0xFFFFFFFC, `alu_op`=00 → `alu_ctl`=2, `alu_b`=0xFFFFFFFC. Then `funct`=0x27 with `alu_op`=10 → `alu_ctl`=12.
- Forward priority: registered `rs_idx`=5, `exmem_rd`=`memwb_rd`=5, both write enables 1, `exmem_result`=0xAA, `memwb_result`=0xBB → `alu_a`=0xAA. Drop `exmem_reg_write` → `alu_a`=0xBB.
- Zero register: `rs_idx`=0, `exmem_rd`=0, `exmem_reg_write`=1, `exmem_result`=7, `rs_data`=0 → `alu_a`=0.
- Stall then flush: load an instruction, hold `stall`=1 for 3 cycles with changing inputs → outputs unchanged. Assert `flush` and `stall` together → `ex_valid`=0, `ex_reg_write`=0, `alu_ctl`=0.
- Illegal funct and reset: `funct`=0x3F, `alu_op`=10, `reg_write`=1 → `alu_ctl`=15, `illegal`=1, `ex_reg_write`=0. Then `reset`=1 for one edge → all registered outputs 0.
